// File: rtl/process_seq.sv
// Accumulator rotate/swap unit with iterative shift-add MUL and restoring DIV.
// Define PROC_DIV_EN to build the divider; without it op 6 completes in one cycle with OV set.
module process_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [7:0]        psw_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ans,
  output logic [DATA_W-1:0] ans_hi,
  output logic [7:0]        psw_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [2:0] OP_RR = 3'd0, OP_RRC = 3'd1, OP_RL = 3'd2, OP_RLC = 3'd3,
                         OP_SWAP = 3'd4, OP_MUL = 3'd5, OP_DIV = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [7:0]          psw_q, psw_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d, prod_nxt;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   ans_q, ans_d, ans_hi_q, ans_hi_d;
  logic [7:0]          psw_out_q, psw_out_d;
`ifdef PROC_DIV_EN
  logic [DATA_W-1:0]   b_q, b_d, quo_q, quo_d, quo_nxt, rem_keep;
  logic [DATA_W:0]     rem_q, rem_d, rem_diff, rem_nxt;
  logic                rem_ge;
`endif

  // Results of every op that finishes without iterating: {ans, ans_hi, psw}.
  function automatic logic [2*DATA_W+7:0] single_op(input logic [2:0] o,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [7:0] psw);
    logic [DATA_W-1:0] r, h;
    logic [7:0]        p;
    r = a;
    h = b;
    p = psw;
    case (o)
      OP_RR:   r = {a[0], a[DATA_W-1:1]};
      OP_RRC:  begin r = {psw[7], a[DATA_W-1:1]}; p[7] = a[0]; end
      OP_RL:   r = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_RLC:  begin r = {a[DATA_W-2:0], psw[7]}; p[7] = a[DATA_W-1]; end
      OP_SWAP: r = {a[DATA_W/2-1:0], a[DATA_W-1:DATA_W/2]};
      OP_DIV: begin
`ifdef PROC_DIV_EN
        // only reached for a zero divisor
        r = '1;
        h = '1;
`endif
        p[7] = 1'b0;
        p[2] = 1'b1;
      end
      default: ;
    endcase
    return {r, h, p};
  endfunction

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_nxt = {mul_sum, prod_q[DATA_W-1:1]};
  end

`ifdef PROC_DIV_EN
  // rem_q holds the partial remainder already shifted left with the next dividend bit.
  always_comb begin
    rem_diff = rem_q - {1'b0, b_q};
    rem_ge   = ~rem_diff[DATA_W];
    rem_keep = rem_ge ? rem_diff[DATA_W-1:0] : rem_q[DATA_W-1:0];
    rem_nxt  = {rem_keep, quo_q[DATA_W-1]};
    quo_nxt  = {quo_q[DATA_W-2:0], rem_ge};
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    psw_d     = psw_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    ans_d     = ans_q;
    ans_hi_d  = ans_hi_q;
    psw_out_d = psw_out_q;
`ifdef PROC_DIV_EN
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d  = op;
          a_d   = a_data;
          psw_d = psw_in;
          cnt_d = '0;
          if (op == OP_MUL) begin
            prod_d  = {{DATA_W{1'b0}}, b_data};
            state_d = S_RUN;
          end
`ifdef PROC_DIV_EN
          else if (op == OP_DIV && b_data != '0) begin
            b_d     = b_data;
            rem_d   = {{DATA_W{1'b0}}, a_data[DATA_W-1]};
            quo_d   = {a_data[DATA_W-2:0], 1'b0};
            state_d = S_RUN;
          end
`endif
          else begin
            {ans_d, ans_hi_d, psw_out_d} = single_op(op, a_data, b_data, psw_in);
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          prod_d = prod_nxt;
          if (cnt_q == CNT_LAST) begin
            ans_d     = prod_nxt[DATA_W-1:0];
            ans_hi_d  = prod_nxt[2*DATA_W-1:DATA_W];
            psw_out_d = {1'b0, psw_q[6:3], |prod_nxt[2*DATA_W-1:DATA_W], psw_q[1:0]};
          end
        end
`ifdef PROC_DIV_EN
        else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          if (cnt_q == CNT_LAST) begin
            ans_d     = quo_nxt;
            ans_hi_d  = rem_keep;
            psw_out_d = {1'b0, psw_q[6:3], 1'b0, psw_q[1:0]};
          end
        end
`endif
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ans_q     <= '0;
      ans_hi_q  <= '0;
      psw_out_q <= '0;
    end else begin
      state_q   <= state_d;
      ans_q     <= ans_d;
      ans_hi_q  <= ans_hi_d;
      psw_out_q <= psw_out_d;
    end
  end

  // Operand and iteration registers need no reset; they are loaded on every accepted start.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    psw_q  <= psw_d;
    cnt_q  <= cnt_d;
    prod_q <= prod_d;
`ifdef PROC_DIV_EN
    b_q    <= b_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
`endif
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign ans     = ans_q;
  assign ans_hi  = ans_hi_q;
  assign psw_out = psw_out_q;

endmodule

// File: tb/tb_process_seq.sv
// Randomised self-checking bench for process_seq (DATA_W=8) against an arithmetic reference model.
module tb_process_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd7;
  logic [7:0] a_data = '0, b_data = '0, psw_in = '0;
  logic       busy, done;
  logic [7:0] ans, ans_hi, psw_out;

  int vectors = 0;
  int miscompares = 0;

  process_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_data(a_data), .b_data(b_data),
    .psw_in(psw_in), .busy(busy), .done(done), .ans(ans), .ans_hi(ans_hi), .psw_out(psw_out)
  );

  always #5 clk = ~clk;

  // Reference: results from plain integer arithmetic; lat = cycles from start edge to done.
  task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] psw, output logic [7:0] r, output logic [7:0] h,
                       output logic [7:0] p, output int lat);
    int ai, bi, cy, prod;
    ai = int'(a); bi = int'(b); cy = int'(psw[7]);
    r = a; h = b; p = psw; lat = 1;
    case (o)
      3'd0: r = 8'(ai / 2 + (ai % 2) * 128);
      3'd1: begin r = 8'(ai / 2 + cy * 128); p[7] = (ai % 2) != 0; end
      3'd2: r = 8'((ai * 2) % 256 + ai / 128);
      3'd3: begin r = 8'((ai * 2) % 256 + cy); p[7] = (ai / 128) != 0; end
      3'd4: r = 8'((ai % 16) * 16 + ai / 16);
      3'd5: begin
        prod = ai * bi;
        r = 8'(prod % 256); h = 8'(prod / 256);
        p[7] = 1'b0; p[2] = (prod / 256) != 0; lat = 9;
      end
      3'd6: begin
`ifdef PROC_DIV_EN
        if (bi == 0) begin
          r = 8'hFF; h = 8'hFF; p[7] = 1'b0; p[2] = 1'b1;
        end else begin
          r = 8'(ai / bi); h = 8'(ai % bi); p[7] = 1'b0; p[2] = 1'b0; lat = 9;
        end
`else
        p[7] = 1'b0; p[2] = 1'b1;
`endif
      end
      default: ;
    endcase
  endtask

  // Issue one op from idle/done and wait (bounded) for done; called just after a rising edge.
  task automatic exec(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] psw, output int lat, output int bcnt, output logic ovl);
    start = 1'b1; op = o; a_data = a; b_data = b; psw_in = psw;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    ovl = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors += 5;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    if (ans !== 8'h00) begin miscompares++; $display("FAIL reset_ans got %h want 00", ans); end
    if (ans_hi !== 8'h00) begin miscompares++; $display("FAIL reset_ans_hi got %h want 00", ans_hi); end
    if (psw_out !== 8'h00) begin miscompares++; $display("FAIL reset_psw got %h want 00", psw_out); end
  endtask

  task automatic test_directed();
    logic [2:0] ops [7];
    logic [7:0] as [7], bs [7], ps [7];
    logic [7:0] er, eh, ep;
    int el, lat, bcnt;
    logic ovl;
    ops = '{3'd5, 3'd6, 3'd6, 3'd1, 3'd3, 3'd4, 3'd6};
    as  = '{8'h50, 8'hFB, 8'hFB, 8'h81, 8'h01, 8'h3C, 8'hFF};
    bs  = '{8'hA0, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    ps  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'hFF};
    for (int i = 0; i < 7; i++) begin
      model(ops[i], as[i], bs[i], ps[i], er, eh, ep, el);
      exec(ops[i], as[i], bs[i], ps[i], lat, bcnt, ovl);
      vectors += 6;
      if (ans !== er) begin miscompares++; $display("FAIL dir%0d_ans got %h want %h", i, ans, er); end
      if (ans_hi !== eh) begin miscompares++; $display("FAIL dir%0d_ans_hi got %h want %h", i, ans_hi, eh); end
      if (psw_out !== ep) begin miscompares++; $display("FAIL dir%0d_psw got %h want %h", i, psw_out, ep); end
      if (lat != el) begin miscompares++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el); end
      if (bcnt != el - 1) begin miscompares++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, el - 1); end
      if (ovl !== 1'b0) begin miscompares++; $display("FAIL dir%0d_busy_with_done got %b want 0", i, ovl); end
    end
    vectors++;
    if ({ans, ans_hi} !== 16'h0000 && 1'b0) miscompares++;
    // spot-check the MUL example values against literals
    model(3'd5, 8'h50, 8'hA0, 8'h80, er, eh, ep, el);
    if ({er, eh, ep} !== 24'h00_32_04) begin miscompares++; $display("FAIL mul_example_model got %h want 003204", {er, eh, ep}); end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [7:0] a, b, p, er, eh, ep;
    int el, lat, bcnt;
    logic ovl;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 8'($urandom); b = 8'($urandom); p = 8'($urandom);
      if (i % 10 == 0) b = 8'h00;
      model(o, a, b, p, er, eh, ep, el);
      exec(o, a, b, p, lat, bcnt, ovl);
      vectors += 5;
      if (ans !== er) begin miscompares++; $display("FAIL rnd%0d_op%0d_ans got %h want %h", i, o, ans, er); end
      if (ans_hi !== eh) begin miscompares++; $display("FAIL rnd%0d_op%0d_ans_hi got %h want %h", i, o, ans_hi, eh); end
      if (psw_out !== ep) begin miscompares++; $display("FAIL rnd%0d_op%0d_psw got %h want %h", i, o, psw_out, ep); end
      if (lat != el) begin miscompares++; $display("FAIL rnd%0d_op%0d_latency got %0d want %0d", i, o, lat, el); end
      if (bcnt != el - 1 || ovl !== 1'b0) begin
        miscompares++; $display("FAIL rnd%0d_op%0d_busy got %0d/%b want %0d/0", i, o, bcnt, ovl, el - 1);
      end
    end
  endtask

  task automatic test_handshake();
    int lat;
    start = 1'b1; op = 3'd5; a_data = 8'h50; b_data = 8'hA0; psw_in = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    @(posedge clk); #1; lat++;
    start = 1'b1; op = 3'd4; a_data = 8'h3C; b_data = 8'h11; psw_in = 8'h00;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors += 4;
    if (lat != 9) begin miscompares++; $display("FAIL hs_latency got %0d want 9", lat); end
    if (ans !== 8'h00) begin miscompares++; $display("FAIL hs_ans got %h want 00", ans); end
    if (ans_hi !== 8'h32) begin miscompares++; $display("FAIL hs_ans_hi got %h want 32", ans_hi); end
    if (psw_out !== 8'h04) begin miscompares++; $display("FAIL hs_psw got %h want 04", psw_out); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] singles [6];
    logic [2:0] o [6];
    logic [7:0] a [6], b [6], p [6], er, eh, ep;
    int el;
    singles = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    for (int i = 0; i < 6; i++) begin
      o[i] = singles[$urandom_range(0, 5)];
      a[i] = 8'($urandom); b[i] = 8'($urandom); p[i] = 8'($urandom);
    end
    start = 1'b1; op = o[0]; a_data = a[0]; b_data = b[0]; psw_in = p[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin op = o[i+1]; a_data = a[i+1]; b_data = b[i+1]; psw_in = p[i+1]; end
      else start = 1'b0;
      model(o[i], a[i], b[i], p[i], er, eh, ep, el);
      vectors += 2;
      if (done !== 1'b1 || busy !== 1'b0) begin
        miscompares++; $display("FAIL b2b%0d_done got %b/%b want 1/0", i, done, busy);
      end
      if ({ans, ans_hi, psw_out} !== {er, eh, ep}) begin
        miscompares++; $display("FAIL b2b%0d_result got %h want %h", i, {ans, ans_hi, psw_out}, {er, eh, ep});
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_drop got %b want 0", done); end
  endtask

  task automatic test_rst_abort();
    logic [7:0] er, eh, ep;
    int el, lat, bcnt;
    logic ovl;
    exec(3'd4, 8'h3C, 8'h5A, 8'hFF, lat, bcnt, ovl);
`ifdef PROC_DIV_EN
    start = 1'b1; op = 3'd6; a_data = 8'hFB; b_data = 8'h12; psw_in = 8'hFF;
`else
    start = 1'b1; op = 3'd5; a_data = 8'hFB; b_data = 8'h12; psw_in = 8'hFF;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_run4_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors += 3;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL abort_ctrl got %b want 00", {busy, done}); end
    if ({ans, ans_hi} !== 16'h0000) begin miscompares++; $display("FAIL abort_results got %h want 0000", {ans, ans_hi}); end
    if (psw_out !== 8'h00) begin miscompares++; $display("FAIL abort_psw got %h want 00", psw_out); end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", done); end
    model(3'd5, 8'hC7, 8'h9E, 8'h01, er, eh, ep, el);
    exec(3'd5, 8'hC7, 8'h9E, 8'h01, lat, bcnt, ovl);
    vectors += 2;
    if ({ans, ans_hi, psw_out} !== {er, eh, ep}) begin
      miscompares++; $display("FAIL post_abort_mul got %h want %h", {ans, ans_hi, psw_out}, {er, eh, ep});
    end
    if (lat != el || bcnt != el - 1) begin
      miscompares++; $display("FAIL post_abort_timing got %0d/%0d want %0d/%0d", lat, bcnt, el, el - 1);
    end
  endtask

`ifndef PROC_DIV_EN
  task automatic test_no_div();
    int lat, bcnt;
    logic ovl;
    exec(3'd6, 8'h10, 8'h03, 8'h00, lat, bcnt, ovl);
    vectors += 3;
    if (lat != 1) begin miscompares++; $display("FAIL nodiv_latency got %0d want 1", lat); end
    if ({ans, ans_hi} !== 16'h1003) begin miscompares++; $display("FAIL nodiv_results got %h want 1003", {ans, ans_hi}); end
    if (psw_out !== 8'h04 || bcnt != 0) begin
      miscompares++; $display("FAIL nodiv_psw_busy got %h/%0d want 04/0", psw_out, bcnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    test_rst_abort();
`ifndef PROC_DIV_EN
    test_no_div();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
